sccb_config_ctrl: RTL and testbench

- Sequences power-up configuration of the OV7670 camera over its SCCB (I2C-like) 2-wire bus.
- Walks an internal register table and issues one 3-phase write per entry: device ID 0x42, register address, data.
- Honours embedded delay entries and raises done when the table is exhausted.
- Sits beside clockdiv in the toplevel, clocked from clk_50; the vga640x480 path does not start consuming camera pixels until done=1.

---
 rtl/sccb_config_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sccb_config_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_ctrl.sv
// sccb_config_ctrl: OV7670 power-up register loader over the SCCB 2-wire bus.
// Walks a register ROM and sends one 3-phase write {0x42, addr, data} per
// entry. Stalls for DELAY_CYC on a 0xF0F0 entry and stops at 0xFFFF.
// Optional build macro SCCB_ACK_CHECK_EN: samples siod_i in the don't-care
// slots and raises a sticky err on a NACK (1).
// Handshake: start is a one-cycle pulse. It is accepted only in DONE and is
// ignored in every other state; busy/done report whether the loader owns the bus.
module sccb_config_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int SCCB_HZ   = 100000,
    parameter int BOOT_CYC  = 50000,
    parameter int DELAY_CYC = 500000,
    parameter int GAP_QTR   = 8
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    input  logic       siod_i,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
    localparam int QW   = $clog2(QDIV + 1);
    localparam int CMAX = (BOOT_CYC > DELAY_CYC) ? BOOT_CYC : DELAY_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(GAP_QTR + 4);
    localparam int IW   = 3;

    localparam logic [TW-1:0] T0 = TW'(0);
    localparam logic [TW-1:0] T1 = TW'(1);
    localparam logic [TW-1:0] T3 = TW'(3);

    typedef enum logic [2:0] {
        BOOT_WAIT, FETCH, START, BITS, STOP, GAP, DELAY, DONE
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [QW-1:0] qcnt, qcnt_d;
    logic [TW-1:0] tq, tq_d;
    logic [4:0]    slot, slot_d;
    logic [26:0]   sr, sr_d;
    logic          sioc_d, siod_oe_d;
    logic [15:0]   entry;
    logic          tick;

    // Register table: {addr, data}; 0xF0F0 = delay, 0xFFFF = end of table.
    always_comb begin
        entry = 16'hFFFF;
        case (idx)
            3'd0: entry = 16'h1280;  // COM7 soft reset
            3'd1: entry = 16'hF0F0;  // settle after soft reset
            3'd2: entry = 16'h1204;  // COM7 RGB output
            3'd3: entry = 16'h40D0;  // COM15 RGB565, full range
            3'd4: entry = 16'h3A04;  // TSLB output sequence
            3'd5: entry = 16'h8C00;  // RGB444 off
            3'd6: entry = 16'h1100;  // CLKRC no prescale
            default: entry = 16'hFFFF;
        endcase
    end

    assign tick      = (qcnt == QW'(QDIV - 1));
    assign siod_o    = 1'b0;
    assign busy      = (state != DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // Next-state and bus sequencing; timers restart on every state change.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt + CW'(1);
        qcnt_d    = tick ? '0 : qcnt + QW'(1);
        tq_d      = tick ? tq + TW'(1) : tq;
        slot_d    = slot;
        sr_d      = sr;
        sioc_d    = sioc;
        siod_oe_d = siod_oe;
        case (state)
            BOOT_WAIT: if (cnt == CW'(BOOT_CYC - 1)) state_d = FETCH;
            FETCH: begin
                if (entry == 16'hFFFF) state_d = DONE;
                else if (entry == 16'hF0F0) state_d = DELAY;
                else begin
                    // A 1 in each ninth slot releases siod for the slave's bit.
                    sr_d    = {8'h42, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
                    slot_d  = 5'd0;
                    state_d = START;
                end
            end
            START: if (tick) begin
                if (tq == T0) siod_oe_d = 1'b1;
                else begin
                    sioc_d  = 1'b0;
                    state_d = BITS;
                end
            end
            BITS: if (tick) begin
                if (tq == T0) siod_oe_d = ~sr[26];
                else if (tq == T1) sioc_d = 1'b1;
                else if (tq == T3) begin
                    sioc_d = 1'b0;
                    tq_d   = '0;
                    if (slot == 5'd26) state_d = STOP;
                    else begin
                        slot_d = slot + 5'd1;
                        sr_d   = {sr[25:0], 1'b0};
                    end
                end
            end
            STOP: if (tick) begin
                if (tq == T0) siod_oe_d = 1'b1;
                else if (tq == T1) sioc_d = 1'b1;
                else begin
                    siod_oe_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: if (tick && tq == TW'(GAP_QTR - 1)) begin
                idx_d   = idx + IW'(1);
                state_d = FETCH;
            end
            DELAY: if (cnt == CW'(DELAY_CYC - 1)) begin
                idx_d   = idx + IW'(1);
                state_d = FETCH;
            end
            DONE: if (start) begin
                idx_d   = '0;
                state_d = FETCH;
            end
            default: state_d = BOOT_WAIT;
        endcase
        if (state_d != state) begin
            cnt_d  = '0;
            qcnt_d = '0;
            tq_d   = '0;
        end
    end

    // State, timers and registered bus outputs; reset releases the bus at once.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state   <= BOOT_WAIT;
            idx     <= '0;
            cnt     <= '0;
            qcnt    <= '0;
            tq      <= '0;
            slot    <= '0;
            sr      <= '0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            qcnt    <= qcnt_d;
            tq      <= tq_d;
            slot    <= slot_d;
            sr      <= sr_d;
            sioc    <= sioc_d;
            siod_oe <= siod_oe_d;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic err_q;
    logic ack_slot;

    assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
    assign err      = err_q;

    // Sticky NACK flag: sampled mid-high of each ack slot, cleared by an accepted start.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if (state == DONE && start) err_q <= 1'b0;
        else if (state == BITS && tick && tq == TW'(2) && ack_slot && siod_i) err_q <= 1'b1;
    end
`else
    logic unused_siod_i;

    assign unused_siod_i = siod_i;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_config_ctrl.sv
// tb_sccb_config_ctrl: bus-level checker for sccb_config_ctrl with scaled timing.
// A bus monitor decodes START/bits/STOP from sioc/siod_oe; a reference model
// computes the expected write list and timing from the register table.
module tb_sccb_config_ctrl;

  localparam int Q       = 4;     // 400 / (4 * 25)
  localparam int BOOT    = 40;
  localparam int DLY     = 150;
  localparam int GAP     = 8;
  localparam int TXN_Q   = 2 + 27 * 4 + 3 + GAP;
  localparam int TBL_N   = 8;
  localparam int BUDGET  = 20000;

  logic       clk_50;
  logic       rst;
  logic       start;
  logic       sioc;
  logic       siod_o;
  logic       siod_oe;
  logic       siod_i;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int stray = 0;
  int ack_lo = 0;
  int ack_hi = 0;

  logic [15:0] ref_tbl [TBL_N] = '{16'h1280, 16'hF0F0, 16'h1204, 16'h40D0,
                                   16'h3A04, 16'h8C00, 16'h1100, 16'hFFFF};

  logic [47:0] exp_q[$];  // {start cycle, entry}
  logic [63:0] obs_q[$];  // {start cycle, pulse count, 27 slot bits}

  sccb_config_ctrl #(
    .CLK_HZ(400), .SCCB_HZ(25), .BOOT_CYC(BOOT), .DELAY_CYC(DLY), .GAP_QTR(GAP)
  ) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .sioc(sioc), .siod_o(siod_o),
    .siod_oe(siod_oe), .siod_i(siod_i), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Slave data line: NACK window under the ack build, noise otherwise
  initial siod_i = 1'b0;
  always @(negedge clk_50) begin
`ifdef SCCB_ACK_CHECK_EN
    siod_i = (cyc >= ack_lo && cyc < ack_hi);
`else
    siod_i = 1'($urandom_range(0, 1));
`endif
  end

  // Bus monitor
  logic        prev_sioc = 1'b1;
  logic        prev_oe = 1'b0;
  logic        in_txn = 1'b0;
  logic        have_pend = 1'b0;
  logic        pend = 1'b0;
  logic [26:0] bits = '0;
  int          nb = 0;
  int          t_start = 0;

  always @(negedge clk_50) begin
    if (!rst) begin
      in_txn = 1'b0;
      have_pend = 1'b0;
    end else if (!in_txn) begin
      if (sioc && prev_sioc && !prev_oe && siod_oe) begin
        in_txn = 1'b1;
        t_start = cyc;
        bits = '0;
        nb = 0;
        have_pend = 1'b0;
      end else if (sioc != prev_sioc || siod_oe != prev_oe) begin
        stray++;
      end
    end else begin
      if (prev_sioc && sioc && prev_oe && !siod_oe) begin
        obs_q.push_back({32'(t_start), 5'((nb > 31) ? 31 : nb), bits});
        in_txn = 1'b0;
      end else if (!prev_sioc && sioc) begin
        pend = ~siod_oe;
        have_pend = 1'b1;
      end else if (prev_sioc && !sioc && have_pend) begin
        bits = {bits[25:0], pend};
        nb++;
        have_pend = 1'b0;
      end
    end
    prev_sioc = sioc;
    prev_oe = siod_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: from the cycle f at which the first entry is fetched,
  // list the expected writes and the cycle at which done rises.
  task automatic build_model(input int f_in, output int done_t);
    int f;
    bit fin;
    f = f_in;
    done_t = -1;
    fin = 1'b0;
    for (int i = 0; i < TBL_N; i++) begin
      if (!fin) begin
        if (ref_tbl[i] == 16'hFFFF) begin
          done_t = f + 1;
          fin = 1'b1;
        end else if (ref_tbl[i] == 16'hF0F0) begin
          f = f + 1 + DLY;
        end else begin
          exp_q.push_back({32'(f + 1 + Q), ref_tbl[i]});
          f = f + 1 + TXN_Q * Q;
        end
      end
    end
  endtask

  task automatic run_until_done(input int exp_done, input logic exp_err);
    int budget;
    budget = 0;
    @(negedge clk_50);
    while (!done && budget < BUDGET) begin
      start = (cyc < exp_done - 3) && ($urandom_range(0, 31) == 0);
      @(negedge clk_50);
      budget++;
    end
    start = 1'b0;
    check("done_time", 32'(cyc), 32'(exp_done));
    check("busy_at_done", 32'(busy), 32'(0));
    check("sioc_idle", 32'(sioc), 32'(1));
    check("oe_idle", 32'(siod_oe), 32'(0));
    check("err_at_done", 32'(err), 32'(exp_err));
  endtask

  task automatic compare_phase(input string ph);
    logic [47:0] e;
    logic [63:0] o;
    check({ph, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({ph, "_start_time"}, o[63:32], e[47:16]);
      check({ph, "_pulses"}, 32'(o[31:27]), 32'(27));
      check({ph, "_dev_id"}, 32'(o[26:19]), 32'h42);
      check({ph, "_reg_addr"}, 32'(o[17:10]), 32'(e[15:8]));
      check({ph, "_reg_data"}, 32'(o[8:1]), 32'(e[7:0]));
      check({ph, "_ack_release"}, 32'({o[18], o[9], o[0]}), 32'(3'b111));
    end
    exp_q.delete();
    obs_q.delete();
    check({ph, "_stray_bus"}, 32'(stray), 32'(0));
  endtask

  initial begin
    int c;
    int done_t;
    int target;
    int budget;
    logic exp_err1;
`ifdef SCCB_ACK_CHECK_EN
    exp_err1 = 1'b1;
`else
    exp_err1 = 1'b0;
`endif
    rst = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk_50);
    check("rst_sioc", 32'(sioc), 32'(1));
    check("rst_oe", 32'(siod_oe), 32'(0));
    check("rst_siod_o", 32'(siod_o), 32'(0));
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));

    // Phase 1: boot sequence with random ignored start pulses
    c = cyc;
    ack_lo = c + BOOT + 1 + 2 * Q + 4 * Q * 17;
    ack_hi = ack_lo + 4 * Q;
    rst = 1'b1;
    build_model(c + BOOT, done_t);
    run_until_done(done_t, exp_err1);
    compare_phase("boot");
    ack_lo = 0;
    ack_hi = 0;

    // Phase 2: restart from DONE, no boot wait
    repeat ($urandom_range(1, 20)) @(negedge clk_50);
    c = cyc;
    start = 1'b1;
    build_model(c + 1, done_t);
    @(negedge clk_50);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'(1));
    check("restart_done", 32'(done), 32'(0));
    run_until_done(done_t, 1'b0);
    compare_phase("restart");

    // Phase 3: reset in the data byte of a restarted write
    repeat ($urandom_range(1, 20)) @(negedge clk_50);
    c = cyc;
    start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    target = c + 2 + 2 * Q + 4 * Q * 18 + int'($urandom_range(0, 4 * Q * 8 - 1));
    budget = 0;
    while (cyc < target && budget < BUDGET) begin
      @(negedge clk_50);
      budget++;
    end
    while (sioc && budget < BUDGET) begin
      @(negedge clk_50);
      budget++;
    end
    check("mid_wait_bounded", 32'(budget < BUDGET), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_sioc", 32'(sioc), 32'(1));
    check("mid_rst_oe", 32'(siod_oe), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(1));
    repeat (3) @(negedge clk_50);
    c = cyc;
    rst = 1'b1;
    build_model(c + BOOT, done_t);
    run_until_done(done_t, 1'b0);
    compare_phase("reboot");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
